// File: rtl/sar_search_if.sv
// Handshake bundle between the successive-approximation search engine and
// whoever requests a search and answers its comparisons.
interface sar_search_if;
    logic       start;
    logic [3:0] probe;
    logic       probe_valid;
    logic       cmp_valid;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       cmp_eq;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       found;
    logic       err;

    // Search engine side
    modport slave (
        input  start, cmp_valid, cmp_gt, cmp_lt, cmp_eq,
        output probe, probe_valid, busy, done, result, found, err
    );

    // Requester / comparator side
    modport master (
        output start, cmp_valid, cmp_gt, cmp_lt, cmp_eq,
        input  probe, probe_valid, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search.sv
// 4-bit successive-approximation search. Each trial offers a probe value to an
// external comparator and keeps or drops the trial bit depending on whether the
// target is above or below the probe. An equal answer ends the search early; a
// final VERIFY probe confirms the accumulated value after the last bit.
module sar_search (
    input  logic         clk,
    input  logic         rst_n,
    sar_search_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        VERIFY,
        FINISH
    } state_t;

    // Cycles without a comparator answer before giving up (15 cycles total).
    localparam logic [3:0] WAIT_LIMIT = 4'd14;

    state_t     state_reg;
    logic [3:0] acc_reg;
    logic [1:0] ptr_reg;
    logic [3:0] wait_cnt_reg;
    logic [3:0] probe_reg;
    logic       probe_valid_reg;
    logic       busy_reg;
    logic       done_reg;
    logic [3:0] result_reg;
    logic       found_reg;
    logic       err_reg;

    logic [3:0] trial_mask;
    logic       one_flag;
    logic [3:0] acc_next;

    // One-hot mask of the bit currently under trial.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_trial_mask
            assign trial_mask[gi] = (ptr_reg == gi[1:0]);
        end
    endgenerate

    // A comparator answer is well-formed only with exactly one flag raised.
    assign one_flag = (bus.cmp_gt ^ bus.cmp_lt ^ bus.cmp_eq)
                    & ~(bus.cmp_gt & bus.cmp_lt & bus.cmp_eq);

    // Target above the probe keeps the trial bit (probe already holds it);
    // target below leaves the accumulator without it.
    assign acc_next = bus.cmp_gt ? probe_reg : acc_reg;

    // Search sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            acc_reg         <= 4'd0;
            ptr_reg         <= 2'd3;
            wait_cnt_reg    <= 4'd0;
            probe_reg       <= 4'd0;
            probe_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            result_reg      <= 4'd0;
            found_reg       <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg        <= 1'b0;
                    probe_valid_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                    if (bus.start) begin
                        acc_reg   <= 4'd0;
                        ptr_reg   <= 2'd3;
                        found_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end

                LOAD: begin
                    probe_reg       <= acc_reg | trial_mask;
                    probe_valid_reg <= 1'b1;
                    wait_cnt_reg    <= 4'd0;
                    state_reg       <= WAIT;
                end

                WAIT: begin
                    if (bus.cmp_valid) begin
                        if (!one_flag) begin
                            err_reg         <= 1'b1;
                            found_reg       <= 1'b0;
                            result_reg      <= probe_reg;
                            probe_valid_reg <= 1'b0;
                            done_reg        <= 1'b1;
                            state_reg       <= FINISH;
                        end else if (bus.cmp_eq) begin
                            result_reg      <= probe_reg;
                            found_reg       <= 1'b1;
                            probe_valid_reg <= 1'b0;
                            done_reg        <= 1'b1;
                            state_reg       <= FINISH;
                        end else begin
                            acc_reg <= acc_next;
                            if (ptr_reg != 2'd0) begin
                                ptr_reg         <= ptr_reg - 2'd1;
                                probe_valid_reg <= 1'b0;
                                state_reg       <= LOAD;
                            end else begin
                                // Last bit decided: offer the final value for confirmation.
                                probe_reg       <= acc_next;
                                probe_valid_reg <= 1'b1;
                                wait_cnt_reg    <= 4'd0;
                                state_reg       <= VERIFY;
                            end
                        end
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        err_reg         <= 1'b1;
                        found_reg       <= 1'b0;
                        probe_valid_reg <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= FINISH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end

                VERIFY: begin
                    if (bus.cmp_valid) begin
                        result_reg      <= probe_reg;
                        probe_valid_reg <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= FINISH;
                        if (one_flag) begin
                            found_reg <= bus.cmp_eq;
                        end else begin
                            err_reg   <= 1'b1;
                            found_reg <= 1'b0;
                        end
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        err_reg         <= 1'b1;
                        found_reg       <= 1'b0;
                        probe_valid_reg <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= FINISH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end

                FINISH: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.probe       = probe_reg;
    assign bus.probe_valid = probe_valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.result      = result_reg;
    assign bus.found       = found_reg;
    assign bus.err         = err_reg;

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port start, input, 1, search request; sampled only in IDLE.
REQ-004 SHALL have port probe, output, 4, trial value driven to external comparator as its B operand.
REQ-005 SHALL have port probe_valid, output, 1, probe stable and awaiting comparison.
REQ-006 SHALL have ports cmp_valid, cmp_gt, cmp_lt, cmp_eq, input, 1 each, comparator response: target >, <, = probe.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port result, output, 4, located target value; held until next accepted start.
REQ-010 SHALL have ports found and err, output, 1 each, status qualified by done.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, WAIT, VERIFY, FINISH.
REQ-012 IDLE: start=1 -> LOAD; clears trial value, sets bit pointer to 3, clears found/err.
REQ-013 LOAD (1 cycle, probe_valid=0): probe = accumulated value OR trial bit at pointer; -> WAIT.
REQ-014 WAIT: probe_valid=1, probe constant; cmp_* ignored unless cmp_valid=1.
REQ-015 On cmp_valid with exactly one flag high: gt keeps trial bit; lt clears it; eq captures probe into result, sets found, -> FINISH (early exit).
REQ-016 After gt/lt decision: pointer>0 -> decrement, -> LOAD; pointer=0 -> VERIFY.
REQ-017 VERIFY: probe = accumulated value, probe_valid=1; on cmp_valid, result=probe, found=cmp_eq; -> FINISH.
REQ-018 cmp_valid with zero or more than one flag high (WAIT or VERIFY): err=1, found=0, result=current probe, -> FINISH.
REQ-019 4-bit wait counter resets on entry to WAIT/VERIFY; reaching 15 cycles without cmp_valid: err=1, found=0, -> FINISH.
REQ-020 FINISH (1 cycle): done=1, busy=1; -> IDLE; start during FINISH ignored.
REQ-021 start while busy SHALL be ignored; no queuing.
REQ-022 cmp_valid outside WAIT/VERIFY SHALL be ignored.
REQ-023 Trial arithmetic SHALL be 4-bit unsigned; no carry beyond bit 3.
REQ-024 Worst-case latency with cmp_valid same cycle as probe_valid: 4 trials x 2 cycles + VERIFY 1 + FINISH 1 = 10 cycles from start to done.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE regardless of state, including mid-search.
REQ-026 Reset values: probe=0, probe_valid=0, busy=0, done=0, result=0, found=0, err=0, wait counter=0, pointer=3.
REQ-027 start asserted on the edge rst_n is low SHALL be discarded.

Verification
REQ-028 Target 11, model answers in 1 cycle: probes 8(gt),12(lt),10(gt),11(eq) -> done, result=11, found=1, err=0.
REQ-029 Target 0: probes 8,4,2,1 all lt, VERIFY probe 0 eq -> result=0, found=1, 10-cycle latency.
REQ-030 Target 8: first probe 8 eq -> early exit, done 3 cycles after start, result=8.
REQ-031 Comparator silent 15 cycles in WAIT -> done, err=1, found=0, probe_valid low next cycle.
REQ-032 cmp_gt=cmp_lt=1 with cmp_valid -> err=1, found=0, result=current probe.
REQ-033 rst_n low during second WAIT -> next cycle busy=0, probe_valid=0, result=0; new start completes normally.
